// File: rtl/trap_seq_if.sv
// rtl/trap_seq_if.sv - trap sequencer signal bundle; master drives requests, slave is the sequencer
interface trap_seq_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  exception_req;
    logic                  int_req;
    logic                  mret;
    logic [ADDR_WIDTH-1:0] vector_addr;
    logic [ADDR_WIDTH-1:0] mepc;
    logic                  pipe_idle;
    logic                  fetch_ack;
    logic                  stall;
    logic                  flush;
    logic                  trap_enter;
    logic                  trap_exit;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  drain_err;
    logic                  busy;
    logic [15:0]           lat_last;
    logic [15:0]           lat_max;

    modport master (
        output exception_req, int_req, mret, vector_addr, mepc, pipe_idle, fetch_ack,
        input  stall, flush, trap_enter, trap_exit, redirect_valid, redirect_pc,
               drain_err, busy, lat_last, lat_max
    );

    modport slave (
        input  exception_req, int_req, mret, vector_addr, mepc, pipe_idle, fetch_ack,
        output stall, flush, trap_enter, trap_exit, redirect_valid, redirect_pc,
               drain_err, busy, lat_last, lat_max
    );
endinterface

// File: rtl/trap_seq.sv
// rtl/trap_seq.sv - trap entry/return sequencer: arbitrate, drain, commit, redirect fetch.
// Optional KRV_TRAP_LAT_CNT_EN adds request-to-ack latency counters (lat_last/lat_max).
module trap_seq #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic      cpu_clk,
    input  logic      cpu_rst,
    trap_seq_if.slave bus
);
    localparam int CW = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CAPTURE, REDIRECT} state_t;
    typedef enum logic [1:0] {EXC, INT, RET} kind_t;

    state_t                state, state_nxt;
    kind_t                 kind, kind_nxt;
    logic [CW-1:0]         drain_cnt, drain_cnt_nxt;
    logic [ADDR_WIDTH-1:0] pc_q, pc_nxt;
    logic                  flush_q, flush_nxt;
    logic                  enter_q, enter_nxt;
    logic                  exit_q, exit_nxt;
    logic                  drain_err_q, err_set;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state       <= IDLE;
            kind        <= EXC;
            drain_cnt   <= '0;
            pc_q        <= '0;
            flush_q     <= 1'b0;
            enter_q     <= 1'b0;
            exit_q      <= 1'b0;
            drain_err_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            kind        <= kind_nxt;
            drain_cnt   <= drain_cnt_nxt;
            pc_q        <= pc_nxt;
            flush_q     <= flush_nxt;
            enter_q     <= enter_nxt;
            exit_q      <= exit_nxt;
            drain_err_q <= drain_err_q | err_set;
        end
    end

    always_comb begin
        state_nxt     = state;
        kind_nxt      = kind;
        drain_cnt_nxt = drain_cnt;
        pc_nxt        = pc_q;
        flush_nxt     = 1'b0;
        enter_nxt     = 1'b0;
        exit_nxt      = 1'b0;
        err_set       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.exception_req || bus.int_req || bus.mret) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = '0;
                    flush_nxt     = 1'b1;
                    if (bus.exception_req)  kind_nxt = EXC;
                    else if (bus.int_req)   kind_nxt = INT;
                    else                    kind_nxt = RET;
                end
            end
            DRAIN: begin
                // An exception raised while draining for an interrupt takes over the trap.
                if (kind == INT && bus.exception_req) kind_nxt = EXC;
                if (bus.pipe_idle) begin
                    state_nxt = CAPTURE;
                end else if (drain_cnt == CW'(DRAIN_TIMEOUT - 1)) begin
                    state_nxt = CAPTURE;
                    err_set   = 1'b1;
                end else begin
                    drain_cnt_nxt = drain_cnt + CW'(1);
                end
                if (state_nxt == CAPTURE) begin
                    enter_nxt = (kind_nxt != RET);
                    exit_nxt  = (kind_nxt == RET);
                end
            end
            CAPTURE: begin
                pc_nxt    = (kind == RET) ? bus.mepc : bus.vector_addr;
                state_nxt = REDIRECT;
            end
            REDIRECT: begin
                if (bus.fetch_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy           = (state != IDLE);
    assign bus.stall          = (state != IDLE);
    assign bus.redirect_valid = (state == REDIRECT);
    assign bus.redirect_pc    = pc_q;
    assign bus.flush          = flush_q;
    assign bus.trap_enter     = enter_q;
    assign bus.trap_exit      = exit_q;
    assign bus.drain_err      = drain_err_q;

`ifdef KRV_TRAP_LAT_CNT_EN
    logic [15:0] lat_cnt, lat_inc, lat_last_q, lat_max_q;

    assign lat_inc = (lat_cnt == 16'hFFFF) ? 16'hFFFF : lat_cnt + 16'd1;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            lat_cnt    <= '0;
            lat_last_q <= '0;
            lat_max_q  <= '0;
        end else begin
            if (state == IDLE && state_nxt != IDLE) lat_cnt <= '0;
            else if (state != IDLE)                 lat_cnt <= lat_inc;
            if (state == REDIRECT && bus.fetch_ack) begin
                lat_last_q <= lat_inc;
                if (lat_inc > lat_max_q) lat_max_q <= lat_inc;
            end
        end
    end

    assign bus.lat_last = lat_last_q;
    assign bus.lat_max  = lat_max_q;
`else
    assign bus.lat_last = 16'd0;
    assign bus.lat_max  = 16'd0;
`endif
endmodule

// File: tb/tb_trap_seq.sv
// tb/tb_trap_seq.sv - directed self-checking bench for trap_seq
module tb_trap_seq;
`ifdef KRV_TRAP_LAT_CNT_EN
    localparam bit LAT_EN = 1'b1;
`else
    localparam bit LAT_EN = 1'b0;
`endif

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    logic bad;

    trap_seq_if #(.ADDR_WIDTH(32)) bus();

    trap_seq #(.ADDR_WIDTH(32), .DRAIN_TIMEOUT(64)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lat(input int v);
        return LAT_EN ? 32'(v) : 32'd0;
    endfunction

    initial begin
        bus.exception_req = 0; bus.int_req = 0; bus.mret = 0;
        bus.vector_addr = 0; bus.mepc = 0; bus.pipe_idle = 0; bus.fetch_ack = 0;
        step(); step();
        cpu_rst = 0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_flush", bus.flush, 0);
        chk("rst_rv", bus.redirect_valid, 0);
        chk("rst_pc", bus.redirect_pc, 0);
        chk("rst_err", bus.drain_err, 0);
        chk("rst_lat", {bus.lat_last, bus.lat_max}, 0);

        // basic interrupt, minimum latency
        bus.int_req = 1; bus.pipe_idle = 1; bus.fetch_ack = 1; bus.vector_addr = 32'h100;
        step(); bus.int_req = 0;
        chk("t1_flush", bus.flush, 1);
        chk("t1_stall", bus.stall, 1);
        chk("t1_enter0", bus.trap_enter, 0);
        step();
        chk("t1_flush_off", bus.flush, 0);
        chk("t1_enter", bus.trap_enter, 1);
        chk("t1_rv0", bus.redirect_valid, 0);
        step();
        chk("t1_rv", bus.redirect_valid, 1);
        chk("t1_pc", bus.redirect_pc, 32'h100);
        chk("t1_enter_off", bus.trap_enter, 0);
        step();
        chk("t1_idle", bus.busy, 0);
        chk("t1_stall_off", bus.stall, 0);
        chk("t1_lat_last", bus.lat_last, lat(3));
        chk("t1_lat_max", bus.lat_max, lat(3));

        // exception + interrupt together
        bus.exception_req = 1; bus.int_req = 1; bus.vector_addr = 32'h200;
        step(); bus.exception_req = 0; bus.int_req = 0;
        step();
        chk("t2_enter", bus.trap_enter, 1);
        chk("t2_exit", bus.trap_exit, 0);
        step();
        chk("t2_pc", bus.redirect_pc, 32'h200);
        step();
        chk("t2_idle", bus.busy, 0);

        // exception + mret together: exception wins
        bus.exception_req = 1; bus.mret = 1; bus.mepc = 32'h3000; bus.vector_addr = 32'h300;
        step(); bus.exception_req = 0; bus.mret = 0;
        step();
        chk("t2b_enter", bus.trap_enter, 1);
        chk("t2b_exit", bus.trap_exit, 0);
        step();
        chk("t2b_pc", bus.redirect_pc, 32'h300);
        step();
        chk("t2b_idle", bus.busy, 0);

        // interrupt upgraded by exception while draining
        bus.int_req = 1; bus.pipe_idle = 0; bus.vector_addr = 32'h111;
        step(); bus.int_req = 0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.trap_enter !== 1'b0 || bus.busy !== 1'b1) bad = 1;
        end
        chk("t3_drain_hold", bad, 0);
        bus.exception_req = 1;
        step(); bus.exception_req = 0;
        bus.pipe_idle = 1;
        step();
        chk("t3_enter", bus.trap_enter, 1);
        chk("t3_exit", bus.trap_exit, 0);
        bus.vector_addr = 32'h444;
        step();
        chk("t3_pc", bus.redirect_pc, 32'h444);
        step();
        chk("t3_idle", bus.busy, 0);
        chk("t3_lat_last", bus.lat_last, lat(9));
        chk("t3_err", bus.drain_err, 0);

        // drain timeout
        bus.int_req = 1; bus.pipe_idle = 0; bus.fetch_ack = 0; bus.vector_addr = 32'h600;
        step(); bus.int_req = 0;
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            step();
            if (bus.trap_enter !== 1'b0 || bus.drain_err !== 1'b0 || bus.busy !== 1'b1) bad = 1;
        end
        chk("t4_drain63", bad, 0);
        step();
        chk("t4_enter", bus.trap_enter, 1);
        chk("t4_err", bus.drain_err, 1);
        step();
        chk("t4_rv", bus.redirect_valid, 1);
        step(); step();
        chk("t4_rv_hold", bus.redirect_valid, 1);
        bus.fetch_ack = 1;
        step();
        chk("t4_idle", bus.busy, 0);
        chk("t4_lat_last", bus.lat_last, lat(68));
        bus.int_req = 1; bus.pipe_idle = 1;
        step(); bus.int_req = 0;
        step(); step(); step();
        chk("t4_clean_idle", bus.busy, 0);
        chk("t4_err_sticky", bus.drain_err, 1);
        chk("t4b_lat_last", bus.lat_last, lat(3));
        chk("t4b_lat_max", bus.lat_max, lat(68));

        // mret with delayed ack
        bus.mret = 1; bus.mepc = 32'h2000; bus.fetch_ack = 0;
        step(); bus.mret = 0;
        chk("t5_flush", bus.flush, 1);
        step();
        chk("t5_exit", bus.trap_exit, 1);
        chk("t5_enter", bus.trap_enter, 0);
        step();
        chk("t5_rv1", bus.redirect_valid, 1);
        chk("t5_pc", bus.redirect_pc, 32'h2000);
        chk("t5_exit_off", bus.trap_exit, 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h2000 || bus.trap_exit !== 1'b0) bad = 1;
        end
        chk("t5_rv_hold", bad, 0);
        bus.fetch_ack = 1;
        step();
        chk("t5_idle", bus.busy, 0);
        chk("t5_rv_off", bus.redirect_valid, 0);
        chk("t5_lat_last", bus.lat_last, lat(6));

        // reset while redirecting
        bus.int_req = 1; bus.fetch_ack = 0; bus.vector_addr = 32'h700;
        step(); bus.int_req = 0;
        step(); step();
        chk("t6_rv", bus.redirect_valid, 1);
        cpu_rst = 1;
        step();
        cpu_rst = 0;
        chk("t6_busy", bus.busy, 0);
        chk("t6_outs", {bus.stall, bus.flush, bus.trap_enter, bus.trap_exit,
                        bus.redirect_valid, bus.drain_err}, 0);
        chk("t6_pc", bus.redirect_pc, 0);
        chk("t6_lat", {bus.lat_last, bus.lat_max}, 0);
        bus.int_req = 1; bus.fetch_ack = 1; bus.vector_addr = 32'h500;
        step(); bus.int_req = 0;
        chk("t6b_flush", bus.flush, 1);
        step();
        chk("t6b_enter", bus.trap_enter, 1);
        step();
        chk("t6b_pc", bus.redirect_pc, 32'h500);
        step();
        chk("t6b_idle", bus.busy, 0);
        chk("t6b_lat_max", bus.lat_max, lat(3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
